// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU sequencer: FSM states, instruction classes,
// instruction field positions and condition selectors.
package alu_seq_pkg;

    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
    localparam logic [STATE_W-1:0] ST_LDA  = 3'd1;
    localparam logic [STATE_W-1:0] ST_EXEC = 3'd2;
    localparam logic [STATE_W-1:0] ST_WB   = 3'd3;
    localparam logic [STATE_W-1:0] ST_COND = 3'd4;
    localparam logic [STATE_W-1:0] ST_TURN = 3'd5;
    localparam logic [STATE_W-1:0] ST_DONE = 3'd6;

    localparam int INSTR_W      = 10;
    localparam int CLASS_LSB    = 8;
    localparam int CLASS_W      = 2;
    localparam int ALUOP_LSB    = 6;
    localparam int ALUOP_W      = 2;
    localparam int SUB_BIT      = 5;
    localparam int RA_LSB       = 3;
    localparam int RB_LSB       = 1;
    localparam int REG_W        = 2;
    localparam int COND_SEL_LSB = 4;
    localparam int COND_SEL_W   = 2;
    localparam int COND_INV_BIT = 6;

    localparam logic [CLASS_W-1:0] CLASS_ALU  = 2'b00;
    localparam logic [CLASS_W-1:0] CLASS_CMP  = 2'b01;
    localparam logic [CLASS_W-1:0] CLASS_COND = 2'b10;
    localparam logic [CLASS_W-1:0] CLASS_ILL  = 2'b11;

    localparam logic [COND_SEL_W-1:0] COND_N = 2'd0;
    localparam logic [COND_SEL_W-1:0] COND_Z = 2'd1;
    localparam logic [COND_SEL_W-1:0] COND_V = 2'd2;
    localparam logic [COND_SEL_W-1:0] COND_C = 2'd3;

    localparam int CNT_W = 3;

    function automatic logic [CLASS_W-1:0] instr_class(input logic [INSTR_W-1:1] instr);
        return instr[CLASS_LSB +: CLASS_W];
    endfunction

endpackage

// File: rtl/alu_cond_eval.sv
// Branch condition evaluator: picks one ALU flag, optionally inverts it.
// Purely combinational; the sequencer registers the result.
module alu_cond_eval
    import alu_seq_pkg::*;
(
    input  logic [COND_SEL_W-1:0] cond_sel,
    input  logic                  cond_inv,
    input  logic                  flag_negative,
    input  logic                  flag_nzero,
    input  logic                  flag_overflow,
    input  logic                  flag_carry,
    output logic                  taken
);

    logic raw;

    always_comb begin
        raw = 1'b0;
        case (cond_sel)
            COND_N:  raw = flag_negative;
            // The ALU reports "not zero", so Z is its complement.
            COND_Z:  raw = ~flag_nzero;
            COND_V:  raw = flag_overflow;
            COND_C:  raw = flag_carry;
            default: raw = 1'b0;
        endcase
        taken = raw ^ cond_inv;
    end

endmodule

// File: rtl/alu_sequencer.sv
// Control sequencer for the ALU datapath: runs one micro-instruction per
// handshake, driving bus, latch and write strobes with at most one bus driver.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int REG_SEL_W     = 2,
    parameter int SETTLE_CYCLES = 0
) (
    input  logic                 i_clk,
    input  logic                 i_nReset,
    input  logic                 i_instrValid,
    output logic                 o_instrReady,
    input  logic [INSTR_W-1:0]   i_instr,
    input  logic                 i_flagNegative,
    input  logic                 i_flagNZero,
    input  logic                 i_flagOverflow,
    input  logic                 i_flagCarry,
    output logic [ALUOP_W-1:0]   o_ctrlAluOp,
    output logic                 o_ctrlAluSub,
    output logic                 o_ctrlAluYNWE,
    output logic                 o_ctrlAluNOE,
    output logic                 o_ctrlANWE,
    output logic [REG_SEL_W-1:0] o_ctrlRegSel,
    output logic                 o_ctrlRegNOE,
    output logic                 o_ctrlRegNWE,
    output logic                 o_branchTaken,
    output logic                 o_illegal,
    output logic                 o_done
);

    // Handshake: an instruction is taken on a rising edge where i_instrValid and
    // o_instrReady are both high; o_instrReady is high only in IDLE, so valid is
    // don't-care while busy and the word must be held until that edge.

    localparam logic             USE_TURN    = (SETTLE_CYCLES > 0);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [INSTR_W-1:1] instr_q, instr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STATE_W-1:0] ret_q, ret_d;
    logic               taken_q, taken_d;
    logic               live_q, live_d;
    logic               cond_taken;
    logic               accept;
    logic [CLASS_W-1:0] cls;
    logic [REG_SEL_W-1:0] ra_sel, rb_sel;
    logic               rsvd_unused;

    assign rsvd_unused = i_instr[0];
    assign cls         = instr_class(instr_q);
    assign ra_sel      = REG_SEL_W'(instr_q[RA_LSB +: REG_W]);
    assign rb_sel      = REG_SEL_W'(instr_q[RB_LSB +: REG_W]);
    assign accept      = i_instrValid & o_instrReady;

    alu_cond_eval u_cond_eval (
        .cond_sel      (instr_q[COND_SEL_LSB +: COND_SEL_W]),
        .cond_inv      (instr_q[COND_INV_BIT]),
        .flag_negative (i_flagNegative),
        .flag_nzero    (i_flagNZero),
        .flag_overflow (i_flagOverflow),
        .flag_carry    (i_flagCarry),
        .taken         (cond_taken)
    );

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        ret_d   = ret_q;
        taken_d = taken_q;
        live_d  = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    instr_d = i_instr[INSTR_W-1:1];
                    taken_d = 1'b0;
                    case (i_instr[CLASS_LSB +: CLASS_W])
                        CLASS_ALU, CLASS_CMP: state_d = ST_LDA;
                        CLASS_COND:           state_d = ST_COND;
                        default:              state_d = ST_DONE;
                    endcase
                end
            end
            ST_LDA: begin
                if (USE_TURN) begin
                    state_d = ST_TURN;
                    cnt_d   = SETTLE_LOAD;
                    ret_d   = ST_EXEC;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Compare has no writeback, so the bus simply goes quiet.
                if (cls != CLASS_ALU) begin
                    state_d = ST_DONE;
                end else if (USE_TURN) begin
                    state_d = ST_TURN;
                    cnt_d   = SETTLE_LOAD;
                    ret_d   = ST_WB;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_TURN: begin
                if (cnt_q == '0) begin
                    state_d = ret_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WB:   state_d = ST_DONE;
            ST_COND: begin
                taken_d = cond_taken;
                state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nReset) begin
        if (!i_nReset) begin
            state_q <= ST_IDLE;
            instr_q <= '0;
            cnt_q   <= '0;
            ret_q   <= ST_IDLE;
            taken_q <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
            ret_q   <= ret_d;
            taken_q <= taken_d;
            live_q  <= live_d;
        end
    end

    // Outputs decode only from registers, so reset forces every strobe high at once.
    always_comb begin
        o_instrReady  = 1'b0;
        o_ctrlAluOp   = '0;
        o_ctrlAluSub  = 1'b0;
        o_ctrlAluYNWE = 1'b1;
        o_ctrlAluNOE  = 1'b1;
        o_ctrlANWE    = 1'b1;
        o_ctrlRegSel  = '0;
        o_ctrlRegNOE  = 1'b1;
        o_ctrlRegNWE  = 1'b1;
        o_branchTaken = 1'b0;
        o_illegal     = 1'b0;
        o_done        = 1'b0;
        case (state_q)
            ST_IDLE: o_instrReady = live_q;
            ST_LDA: begin
                o_ctrlAluOp  = instr_q[ALUOP_LSB +: ALUOP_W];
                o_ctrlAluSub = instr_q[SUB_BIT];
                o_ctrlRegSel = ra_sel;
                o_ctrlRegNOE = 1'b0;
                o_ctrlANWE   = 1'b0;
            end
            ST_TURN: begin
                o_ctrlAluOp  = instr_q[ALUOP_LSB +: ALUOP_W];
                o_ctrlAluSub = instr_q[SUB_BIT];
            end
            ST_EXEC: begin
                o_ctrlAluOp   = instr_q[ALUOP_LSB +: ALUOP_W];
                o_ctrlAluSub  = instr_q[SUB_BIT];
                o_ctrlRegSel  = rb_sel;
                o_ctrlRegNOE  = 1'b0;
                o_ctrlAluYNWE = 1'b0;
            end
            ST_WB: begin
                o_ctrlAluOp  = instr_q[ALUOP_LSB +: ALUOP_W];
                o_ctrlAluSub = instr_q[SUB_BIT];
                o_ctrlRegSel = ra_sel;
                o_ctrlAluNOE = 1'b0;
                o_ctrlRegNWE = 1'b0;
            end
            ST_DONE: begin
                o_done        = 1'b1;
                o_illegal     = (cls == CLASS_ILL);
                o_branchTaken = taken_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: two instances (no settle gap and a
// two-cycle gap) driven by directed and random instructions.
module tb_alu_sequencer;

    typedef struct packed {
        logic [4:0] lat;
        logic       illegal;
        logic       taken;
        logic [1:0] n_lda;
        logic [1:0] lda_sel;
        logic [2:0] lda_os;
        logic       lda_drv;
        logic [1:0] n_exe;
        logic [1:0] exe_sel;
        logic [2:0] exe_os;
        logic       exe_drv;
        logic [1:0] n_wb;
        logic [1:0] wb_sel;
        logic [2:0] wb_os;
        logic       wb_drv;
        logic [3:0] n_quiet;
        logic       order_bad;
        logic       leak;
    } txn_t;

    localparam int W = $bits(txn_t);

    logic       clk;
    logic       rst_n;
    logic [1:0] valid;
    logic [9:0] instr;
    logic [3:0] flags; // {N, NZ, V, C}

    logic       ready[2], done[2], taken[2], illegal[2], sub[2];
    logic       ynwe[2], alunoe[2], anwe[2], regnoe[2], regnwe[2];
    logic [1:0] op[2], sel[2];

    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];

    int tests = 0;
    int fails = 0;

    alu_sequencer #(.REG_SEL_W(2), .SETTLE_CYCLES(0)) u_dut0 (
        .i_clk(clk), .i_nReset(rst_n), .i_instrValid(valid[0]), .o_instrReady(ready[0]),
        .i_instr(instr), .i_flagNegative(flags[3]), .i_flagNZero(flags[2]),
        .i_flagOverflow(flags[1]), .i_flagCarry(flags[0]),
        .o_ctrlAluOp(op[0]), .o_ctrlAluSub(sub[0]), .o_ctrlAluYNWE(ynwe[0]),
        .o_ctrlAluNOE(alunoe[0]), .o_ctrlANWE(anwe[0]), .o_ctrlRegSel(sel[0]),
        .o_ctrlRegNOE(regnoe[0]), .o_ctrlRegNWE(regnwe[0]), .o_branchTaken(taken[0]),
        .o_illegal(illegal[0]), .o_done(done[0])
    );

    alu_sequencer #(.REG_SEL_W(2), .SETTLE_CYCLES(2)) u_dut2 (
        .i_clk(clk), .i_nReset(rst_n), .i_instrValid(valid[1]), .o_instrReady(ready[1]),
        .i_instr(instr), .i_flagNegative(flags[3]), .i_flagNZero(flags[2]),
        .i_flagOverflow(flags[1]), .i_flagCarry(flags[0]),
        .o_ctrlAluOp(op[1]), .o_ctrlAluSub(sub[1]), .o_ctrlAluYNWE(ynwe[1]),
        .o_ctrlAluNOE(alunoe[1]), .o_ctrlANWE(anwe[1]), .o_ctrlRegSel(sel[1]),
        .o_ctrlRegNOE(regnoe[1]), .o_ctrlRegNWE(regnwe[1]), .o_branchTaken(taken[1]),
        .o_illegal(illegal[1]), .o_done(done[1])
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic txn_t model(input logic [9:0] ins, input logic [3:0] fl, input int s);
        txn_t t;
        logic [1:0] cls;
        logic       f;
        t   = '0;
        cls = ins[9:8];
        case (cls)
            2'd0: t.lat = 5'(4 + 2 * s);
            2'd1: t.lat = 5'(3 + s);
            2'd2: t.lat = 5'd2;
            default: t.lat = 5'd1;
        endcase
        case (cls)
            2'd0: t.n_quiet = 4'(2 * s);
            2'd1: t.n_quiet = 4'(s);
            2'd2: t.n_quiet = 4'd1;
            default: t.n_quiet = 4'd0;
        endcase
        if (cls == 2'd0 || cls == 2'd1) begin
            t.n_lda = 2'd1; t.lda_sel = ins[4:3]; t.lda_os = ins[7:5]; t.lda_drv = 1'b1;
            t.n_exe = 2'd1; t.exe_sel = ins[2:1]; t.exe_os = ins[7:5]; t.exe_drv = 1'b1;
        end
        if (cls == 2'd0) begin
            t.n_wb = 2'd1; t.wb_sel = ins[4:3]; t.wb_os = ins[7:5]; t.wb_drv = 1'b1;
        end
        t.illegal = (cls == 2'd3);
        if (cls == 2'd2) begin
            case (ins[5:4])
                2'd0: f = fl[3];
                2'd1: f = !fl[2];
                2'd2: f = fl[1];
                default: f = fl[0];
            endcase
            t.taken = f ^ ins[6];
        end
        return t;
    endfunction

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d: got %h, expected %h", name, d, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic send(input int d, input logic [9:0] ins, input logic [3:0] fl);
        txn_t e;
        int   n;
        e = model(ins, fl, (d == 0) ? 0 : 2);
        if (d == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
        instr    = ins;
        valid[d] = 1'b1;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (ready[d]) break;
            n++;
            if (n > 200) break;
        end
        if (!ready[d]) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout dut%0d instr %b", d, ins);
            valid[d] = 1'b0;
            if (d == 0) void'(exp_q0.pop_back()); else void'(exp_q1.pop_back());
            return;
        end
        // Flags change only while the DUT idles, as a registered ALU would.
        flags = fl;
        @(posedge clk);
        #1;
        valid[d] = 1'b0;
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        while (((d == 0) ? exp_q0.size() : exp_q1.size()) != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain", d, (d == 0) ? exp_q0.size() : exp_q1.size(), 0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic busy[2];
        logic dprev[2];
        int   cyc[2];
        int   last[2];
        txn_t obs[2];
        txn_t e;
        int   nph;
        for (int g = 0; g < 2; g++) begin
            busy[g] = 0; dprev[g] = 0; cyc[g] = 0; last[g] = 0; obs[g] = '0;
        end
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                for (int g = 0; g < 2; g++) begin
                    busy[g] = 0; dprev[g] = 0;
                end
                exp_q0.delete();
                exp_q1.delete();
            end else begin
                for (int g = 0; g < 2; g++) begin
                    tests++;
                    if ((!regnoe[g] && !alunoe[g]) || (!regnoe[g] && !regnwe[g])) begin
                        fails++;
                        $display("FAIL bus_invariant dut%0d at %0t: regnoe=%b alunoe=%b regnwe=%b, required no overlap",
                                 g, $time, regnoe[g], alunoe[g], regnwe[g]);
                    end
                    if (dprev[g]) check("ready_after_done", g, ready[g], 1);
                    dprev[g] = done[g];
                    if (busy[g]) begin
                        cyc[g]++;
                        nph = 0;
                        if (!anwe[g]) begin
                            nph++;
                            if (last[g] > 1) obs[g].order_bad = 1'b1;
                            last[g] = 1;
                            if (obs[g].n_lda < 3) obs[g].n_lda = obs[g].n_lda + 2'd1;
                            obs[g].lda_sel = sel[g]; obs[g].lda_os = {op[g], sub[g]}; obs[g].lda_drv = !regnoe[g];
                        end
                        if (!ynwe[g]) begin
                            nph++;
                            if (last[g] > 2) obs[g].order_bad = 1'b1;
                            last[g] = 2;
                            if (obs[g].n_exe < 3) obs[g].n_exe = obs[g].n_exe + 2'd1;
                            obs[g].exe_sel = sel[g]; obs[g].exe_os = {op[g], sub[g]}; obs[g].exe_drv = !regnoe[g];
                        end
                        if (!regnwe[g]) begin
                            nph++;
                            last[g] = 3;
                            if (obs[g].n_wb < 3) obs[g].n_wb = obs[g].n_wb + 2'd1;
                            obs[g].wb_sel = sel[g]; obs[g].wb_os = {op[g], sub[g]}; obs[g].wb_drv = !alunoe[g];
                        end
                        if (nph > 1) obs[g].order_bad = 1'b1;
                        if (nph == 0 && !(regnoe[g] && alunoe[g])) obs[g].order_bad = 1'b1;
                        if (!done[g] && (taken[g] || illegal[g])) obs[g].leak = 1'b1;
                        if (!done[g] && anwe[g] && ynwe[g] && alunoe[g] && regnoe[g] && regnwe[g]
                            && obs[g].n_quiet < 15)
                            obs[g].n_quiet = obs[g].n_quiet + 4'd1;
                        if (done[g]) begin
                            obs[g].lat     = 5'(cyc[g]);
                            obs[g].illegal = illegal[g];
                            obs[g].taken   = taken[g];
                            busy[g] = 0;
                            tests++;
                            if (((g == 0) ? exp_q0.size() : exp_q1.size()) == 0) begin
                                fails++;
                                $display("FAIL no_expected dut%0d: got txn %h, expected none", g, obs[g]);
                            end else begin
                                e = (g == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                                if (obs[g] !== e) begin
                                    fails++;
                                    $display("FAIL txn dut%0d: got %h, expected %h", g, obs[g], e);
                                end
                            end
                        end
                    end else if (done[g]) begin
                        check("spurious_done", g, done[g], 0);
                    end else begin
                        check("idle_quiet", g,
                              {taken[g], illegal[g], ynwe[g], alunoe[g], anwe[g], regnoe[g], regnwe[g]},
                              7'b00_11111);
                    end
                    if (!busy[g] && ready[g] && valid[g]) begin
                        busy[g] = 1; cyc[g] = 0; last[g] = 0; obs[g] = '0;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    localparam logic [9:0] I_ADD  = 10'b00_00_0_01_10_0;
    localparam logic [9:0] I_CMP  = 10'b01_00_1_11_00_0;
    localparam logic [9:0] I_CZ   = 10'b10_0001_0000;
    localparam logic [9:0] I_CNZ  = 10'b10_0101_0000;
    localparam logic [9:0] I_CC   = 10'b10_0011_0000;
    localparam logic [9:0] I_ILL  = 10'b11_0000_0000;
    localparam logic [9:0] I_ILL2 = 10'b11_0101_0101;

    task automatic random_run(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            send(d, 10'($urandom_range(0, 1023)), 4'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b1;
        valid = 2'b00;
        instr = '0;
        flags = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            check("reset_strobes", g, {ynwe[g], alunoe[g], anwe[g], regnoe[g], regnwe[g]}, 5'h1f);
            check("reset_ctrl", g, {op[g], sub[g], sel[g]}, 0);
            check("reset_status", g, {ready[g], done[g], taken[g], illegal[g]}, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int g = 0; g < 2; g++) check("ready_before_edge", g, ready[g], 0);
        @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) check("ready_after_release", g, ready[g], 1);

        send(0, I_ADD, 4'b0000);
        send(0, I_CMP, 4'b1010);
        send(0, I_CZ,  4'b0000);
        send(0, I_CNZ, 4'b0000);
        send(0, I_CC,  4'b0001);
        send(0, I_ILL, 4'b0000);
        send(0, I_ILL2, 4'b0000);
        random_run(0, 40);
        drain(0);

        send(0, I_ADD, 4'b0000);
        @(posedge clk);
        #1;
        check("exec_before_reset", 0, {ynwe[0], regnoe[0]}, 2'b00);
        rst_n = 1'b0;
        #1;
        check("reset_mid_exec", 0, {ynwe[0], regnoe[0], ready[0]}, 3'b110);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_before_edge2", 0, ready[0], 0);
        @(posedge clk);
        #1;
        check("ready_after_release2", 0, ready[0], 1);

        send(1, I_ADD, 4'b0000);
        send(1, I_CMP, 4'b0101);
        send(1, I_CZ,  4'b0100);
        send(1, I_ILL, 4'b0000);
        random_run(1, 30);
        drain(1);
        drain(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
